// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one async FIFO write port among NUM_REQ
// requesters. An IDLE cycle picks an owner, and the owner then gets a tenure of up to MAX_BURST
// writes. The tenure ends early if the owner drops its request. full_i stalls the tenure without
// ending it.
//
// Ports:
//   clk_i        write-domain clock
//   rst_i        asynchronous active-high reset
//   req_i        per-requester level request
//   data_i       requester k's word in bits [k*DATA_WIDTH +: DATA_WIDTH]
//   full_i       FIFO write-side full flag
//   gnt_o        one-hot (or zero) consume strobe, equal to wr_en_o on the owner's bit
//   wr_en_o      FIFO write enable
//   wr_data_o    FIFO write data (owner's word during BURST, 0 in IDLE)
//   stall_cnt_o  saturating count of stalled owner cycles (only with FIFO_WR_ARB_STALL_CNT_EN)
//
// Optional feature macro: FIFO_WR_ARB_STALL_CNT_EN
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  input  logic                          full_i,
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  output logic [15:0]                   stall_cnt_o,
`endif
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          wr_en_o,
  output logic [DATA_WIDTH-1:0]         wr_data_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] LastCnt  = CntW'(MAX_BURST - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_REQ - 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] bcnt_q, bcnt_d;

  logic            owner_req;
  logic [IdxW-1:0] owner_next;
  logic [IdxW-1:0] pick;
  logic            pick_vld;

  assign owner_req  = req_i[owner_q];
  // Modulo increment written out so non-power-of-two NUM_REQ wraps correctly.
  assign owner_next = (owner_q == LastIdx) ? '0 : owner_q + IdxW'(1);

  // First set request at or above rr_ptr_q, wrapping past NUM_REQ-1 to 0.
  always_comb begin : rr_search
    int unsigned     idx;
    logic [IdxW-1:0] idx_t;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    idx_t    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx   = (32'(rr_ptr_q) + i) % NUM_REQ;
      idx_t = IdxW'(idx);
      if (!pick_vld && req_i[idx_t]) begin
        pick_vld = 1'b1;
        pick     = idx_t;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    bcnt_d   = bcnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld && !full_i) begin
          owner_d = pick;
          bcnt_d  = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (!owner_req) begin
          state_d  = StIdle;
          rr_ptr_d = owner_next;
        end else if (!full_i) begin
          bcnt_d = bcnt_q + CntW'(1);
          if (bcnt_q == LastCnt) begin
            state_d  = StIdle;
            rr_ptr_d = owner_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      bcnt_q   <= bcnt_d;
    end
  end

  // Outputs decode from registered state only, so reset clears them without a clock edge.
  always_comb begin
    wr_en_o   = 1'b0;
    gnt_o     = '0;
    wr_data_o = '0;
    if (state_q == StBurst) begin
      wr_en_o        = owner_req & ~full_i;
      gnt_o[owner_q] = wr_en_o;
      wr_data_o      = data_i[owner_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if ((state_q == StBurst) && owner_req && full_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
// Directed scenarios with fixed expectations, then randomized traffic against a behavioural
// tenure model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] data;
  logic          full;
  logic [N-1:0]  gnt;
  logic          wr_en;
  logic [DW-1:0] wr_data;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW),
    .MAX_BURST (MB)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .data_i     (data),
    .full_i     (full),
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    .stall_cnt_o(stall_cnt),
`endif
    .gnt_o      (gnt),
    .wr_en_o    (wr_en),
    .wr_data_o  (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: whether a tenure is active, who owns it, how many words it has written,
  // where the next search starts, and the stall tally.
  int m_busy, m_owner, m_ptr, m_cnt, m_stall;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_stall = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (m_busy == 0) begin
      if (req != 0 && !full) begin
        for (int k = N - 1; k >= 0; k--)
          if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        m_busy = 1;
        m_cnt  = 0;
      end
    end else if (!req[m_owner]) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % N;
    end else if (full) begin
      if (m_stall < 65535) m_stall++;
    end else begin
      m_cnt++;
      if (m_cnt == MB) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic          e_wr;
    logic [N-1:0]  e_gnt;
    logic [DW-1:0] e_data;
    e_wr = 1'b0; e_gnt = '0; e_data = '0;
    if (m_busy != 0) begin
      e_wr   = req[m_owner] && !full;
      e_gnt  = e_wr ? (N'(1) << m_owner) : '0;
      e_data = data[m_owner*DW +: DW];
    end
    check_eq({tag, ".wr_en"}, 32'(wr_en), 32'(e_wr));
    check_eq({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    check_eq({tag, ".wr_data"}, 32'(wr_data), 32'(e_data));
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    check_eq({tag, ".stall_cnt"}, 32'(stall_cnt), m_stall);
`endif
  endtask

  // Called at posedge+1 with inputs already driven; samples mid-cycle.
  task automatic mid(input string tag);
    #4;
    check_model(tag);
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    req = '0; full = 1'b0; data = '0;
    mid("reset");
    edge_step();
    edge_step();
    rst = 1'b0;
  endtask

  logic [9:0] pat;
  int         w;

  initial begin
    rst = 1'b1; req = '0; full = 1'b0; data = '0;
    model_reset();
    #1;
    check_eq("reset.async_wr_en", 32'(wr_en), 0);
    check_eq("reset.async_gnt", 32'(gnt), 0);
    @(posedge clk); #1;
    do_reset();

    // Single requester, six words: 4-word tenure, one IDLE cycle, then the last two.
    pat = 10'b0011011110;
    w   = 0;
    for (int c = 0; c < 10; c++) begin
      req  = (w < 6) ? 4'b0100 : 4'b0000;
      data = '0;
      data[23:16] = 8'hA0 + 8'(w);
      mid("single");
      check_eq("single.gnt_pat", 32'(gnt), pat[c] ? 32'h4 : 32'h0);
      if (pat[c]) begin
        check_eq("single.word", 32'(wr_data), 32'(8'hA0 + 8'(w)));
        w++;
      end
      edge_step();
    end

    // Round robin with everyone requesting: owners 0,1,2,3,0 separated by IDLE cycles.
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      data = $urandom;
      mid("rr");
      check_eq("rr.gnt_order", 32'(gnt), (c % 5 == 0) ? 32'h0 : (32'h1 << ((c / 5) % 4)));
      if (c == 5) check_eq("rr.ptr_after_first", 32'(dut.rr_ptr_q), 1);
      edge_step();
    end

    // Full stall: owner 1 stalls for three cycles after two writes.
    do_reset();
    req = 4'b0010;
    pat = 10'b0011000110;
    for (int c = 0; c < 9; c++) begin
      full = (c >= 3 && c <= 5);
      data = $urandom;
      mid("stall");
      check_eq("stall.gnt_pat", 32'(gnt), pat[c] ? 32'h2 : 32'h0);
      if (full) check_eq("stall.bcnt_held", 32'(dut.bcnt_q), 2);
      edge_step();
    end
    full = 1'b0;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    check_eq("stall.count3", 32'(stall_cnt), 3);
`endif

    // Early release: owner 2 drops after one write; pending requester 0 wins after wrap.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req  = (c < 2) ? 4'b0100 : 4'b0001;
      data = $urandom;
      mid("early");
      case (c)
        1:       check_eq("early.gnt", 32'(gnt), 32'h4);
        4:       check_eq("early.gnt", 32'(gnt), 32'h1);
        default: check_eq("early.gnt", 32'(gnt), 32'h0);
      endcase
      if (c == 3) check_eq("early.ptr", 32'(dut.rr_ptr_q), 3);
      edge_step();
    end

    // Reset mid-burst during owner 3's second write.
    do_reset();
    req = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      data = $urandom;
      mid("rstmid");
      if (c > 0) check_eq("rstmid.gnt", 32'(gnt), 32'h8);
      if (c < 2) edge_step();
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("rstmid.wr_en_drop", 32'(wr_en), 0);
    check_eq("rstmid.gnt_drop", 32'(gnt), 0);
    check_eq("rstmid.data_drop", 32'(wr_data), 0);
    edge_step();
    edge_step();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      mid("rstmid_after");
      check_eq("rstmid.restart_gnt", 32'(gnt), (c == 1) ? 32'h8 : 32'h0);
      if (c == 1) begin
        check_eq("rstmid.bcnt0", 32'(dut.bcnt_q), 0);
        check_eq("rstmid.ptr0", 32'(dut.rr_ptr_q), 0);
      end
      edge_step();
    end

    // Full in IDLE blocks arbitration; first write lands in the second cycle after it drops.
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      full = (c < 5);
      data = $urandom;
      mid("fullidle");
      check_eq("fullidle.gnt", 32'(gnt), (c == 6) ? 32'h1 : 32'h0);
      edge_step();
    end

    // Randomized traffic: level requests that toggle occasionally, random full, random data.
    do_reset();
    req = 4'($urandom);
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(5, 0) == 0) req[b] = ~req[b];
      full = ($urandom_range(3, 0) == 0);
      data = $urandom;
      mid("rand");
      edge_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
